mu0_phase_sequencer: RTL and testbench

Control-phase generator for the MU0 CPU: owns the instruction register and the FETCH/EXEC1/EXEC2 state machine whose outputs feed the combinational instruction decoder. Captures each instruction word from memory during FETCH, and decides whether the instruction needs a second execute phase. Halts on STP or an undefined opcode, and supports free-run and single-instruction step control. Sits between program memory read data and the decoder's phase/opcode inputs.

---
 rtl/mu0_phase_sequencer.sv | 66 ++++++
 tb/tb_mu0_phase_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mu0_phase_sequencer.sv
// mu0_phase_sequencer: MU0 instruction register and FETCH/EXEC1/EXEC2 phase control
// with run/step start, STP/illegal halt and a retired-instruction counter.
module mu0_phase_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             step,
    input  logic [15:0]      mem_q,
    output logic             fetch,
    output logic             exec1,
    output logic             exec2,
    output logic [3:0]       op,
    output logic [11:0]      operand,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [2:0] {IDLE_S, FETCH_S, EXEC1_S, EXEC2_S, HALT_S} state_t;
    state_t      state, nxt;
    logic [15:0] ir;
    logic        is_long, is_stop, is_bad, retire;
    state_t      cont;
    assign op      = ir[15:12];
    assign operand = ir[11:0];
    always_comb begin
        is_long = (op == 4'h0) || (op == 4'h2) || (op == 4'h3);
        is_bad  = op > 4'hA;
        is_stop = (op == 4'h7) || is_bad;
        cont    = run ? FETCH_S : IDLE_S;
        retire  = (state == EXEC2_S) || ((state == EXEC1_S) && !is_long && !is_stop);
        nxt     = state == IDLE_S  ? ((run || step) ? FETCH_S : IDLE_S) :
                  state == FETCH_S ? EXEC1_S :
                  state == EXEC1_S ? (is_long ? EXEC2_S : is_stop ? HALT_S : cont) :
                  state == EXEC2_S ? cont : HALT_S;
    end
    // Outputs are registered from the next state so they line up with it exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE_S;
            fetch     <= 1'b0;
            exec1     <= 1'b0;
            exec2     <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            ir        <= '0;
            instr_cnt <= '0;
        end else begin
            state  <= nxt;
            fetch  <= nxt == FETCH_S;
            exec1  <= nxt == EXEC1_S;
            exec2  <= nxt == EXEC2_S;
            busy   <= (nxt == FETCH_S) || (nxt == EXEC1_S) || (nxt == EXEC2_S);
            halted <= nxt == HALT_S;
            if (state == EXEC1_S && is_bad)
                illegal <= 1'b1;
            if (state == FETCH_S)
                ir <= mem_q;
            if (retire)
                instr_cnt <= instr_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mu0_phase_sequencer.sv
// tb_mu0_phase_sequencer: directed bench with an instruction-position model checked every cycle.
module tb_mu0_phase_sequencer;
    localparam int CW = 4;
    logic          clk = 1'b0, reset_n = 1'b0, run = 1'b0, step = 1'b0;
    logic [15:0]   mem_q;
    logic          fetch, exec1, exec2, busy, halted, illegal;
    logic [3:0]    op;
    logic [11:0]   operand;
    logic [CW-1:0] instr_cnt;
    logic [15:0]   prog [32];
    logic [4:0]    pi;
    int            n_cmp = 0, n_bad = 0;

    mu0_phase_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step), .mem_q(mem_q),
        .fetch(fetch), .exec1(exec1), .exec2(exec2), .op(op), .operand(operand),
        .busy(busy), .halted(halted), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Program memory: each completed fetch advances to the next word.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) pi <= '0;
        else if (fetch) pi <= pi + 5'd1;
    assign mem_q = prog[pi];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_pos is the cycle index within the current instruction (0 = not executing).
    int            m_pos;
    logic          m_halt, m_ill;
    logic [15:0]   m_ir;
    logic [CW-1:0] m_cnt;
    always @(posedge clk or negedge reset_n) begin : mdl
        logic [3:0] o;
        int len;
        if (!reset_n) begin
            m_pos <= 0; m_halt <= 1'b0; m_ill <= 1'b0; m_ir <= '0; m_cnt <= '0;
        end else if (!m_halt) begin
            if (m_pos == 0) m_pos <= (run || step) ? 1 : 0;
            else if (m_pos == 1) begin
                m_ir <= mem_q;
                m_pos <= 2;
            end else begin
                o = m_ir[15:12];
                len = (o == 0 || o == 2 || o == 3) ? 3 : 2;
                if (m_pos == 2 && (o == 7 || o >= 11)) begin
                    m_halt <= 1'b1;
                    m_ill <= (o >= 11);
                    m_pos <= 0;
                end else if (m_pos == len) begin
                    m_cnt <= m_cnt + 1'b1;
                    m_pos <= run ? 1 : 0;
                end else m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("fetch", 32'(fetch), 32'(m_pos == 1));
        chk("exec1", 32'(exec1), 32'(m_pos == 2));
        chk("exec2", 32'(exec2), 32'(m_pos == 3));
        chk("busy", 32'(busy), 32'(m_pos != 0));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("op", 32'(op), 32'(m_ir[15:12]));
        chk("operand", 32'(operand), 32'(m_ir[11:0]));
        chk("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < 32; i++) prog[i] = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; run = 1'b0; step = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    initial begin : stim
        logic [2:0] pat [7];
        pat = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b001};
        fill(16'h0005);
        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(instr_cnt), 0);
        chk("rst_ir", 32'({op, operand}), 0);
        // LDA 5 under RUN, then RUN dropped mid-instruction
        run = 1'b1;
        cyc(1); chk("lda_f", 32'(fetch), 1);
        cyc(1); chk("lda_e1", 32'(exec1), 1); chk("lda_opnd", 32'(operand), 32'h005);
        cyc(1); chk("lda_e2", 32'(exec2), 1); chk("lda_cnt0", 32'(instr_cnt), 0);
        cyc(1); chk("lda_f2", 32'(fetch), 1); chk("lda_cnt1", 32'(instr_cnt), 1);
        run = 1'b0;
        cyc(2); chk("lda_e2b", 32'(exec2), 1);
        cyc(1); chk("lda_idle", 32'(busy), 0); chk("lda_cnt2", 32'(instr_cnt), 2);
        // Program LDI, JMP, ADD, STP under RUN
        do_reset();
        fill(16'h0000);
        prog[0] = 16'h8012; prog[1] = 16'h4003; prog[2] = 16'h2004; prog[3] = 16'h7000;
        run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk("prog_phase", 32'({fetch, exec1, exec2}), 32'(pat[i]));
        end
        cyc(1); chk("prog_cnt", 32'(instr_cnt), 3);
        cyc(1); chk("stp_op", 32'(op), 7);
        cyc(1); chk("stp_halt", 32'(halted), 1); chk("stp_busy", 32'(busy), 0);
        run = 1'b0; step = 1'b1;
        cyc(2); step = 1'b0; run = 1'b1;
        cyc(2);
        chk("halt_sticky", 32'(halted), 1); chk("halt_cnt", 32'(instr_cnt), 3);
        #2 reset_n = 1'b0;
        #1 chk("halt_clr", 32'(halted), 0);
        // Single STEP of SUB, with an ignored STEP during EXEC1
        do_reset();
        fill(16'h3010);
        step = 1'b1;
        cyc(1); step = 1'b0; chk("step_f", 32'(fetch), 1);
        cyc(1); step = 1'b1; chk("step_e1", 32'(exec1), 1);
        cyc(1); step = 1'b0; chk("step_e2", 32'(exec2), 1);
        cyc(1); chk("step_idle", 32'(busy), 0); chk("step_cnt", 32'(instr_cnt), 1);
        cyc(2); chk("step_stay", 32'(busy), 0);
        // Illegal opcode
        do_reset();
        fill(16'hC123);
        run = 1'b1;
        cyc(3);
        chk("ill_halt", 32'(halted), 1); chk("ill_flag", 32'(illegal), 1);
        chk("ill_cnt", 32'(instr_cnt), 0);
        // Async reset during EXEC2 of the second SUB
        do_reset();
        fill(16'h3010);
        run = 1'b1;
        cyc(6); chk("sub_e2", 32'(exec2), 1); chk("sub_cnt", 32'(instr_cnt), 1);
        #2 reset_n = 1'b0;
        #1 chk("arst_phase", 32'({fetch, exec1, exec2, busy}), 0);
        chk("arst_cnt", 32'(instr_cnt), 0); chk("arst_ir", 32'({op, operand}), 0);
        // Counter wrap with 4-bit count: 16 JMPs
        do_reset();
        fill(16'h4000);
        run = 1'b1;
        cyc(31); chk("wrap_15", 32'(instr_cnt), 15);
        cyc(2);  chk("wrap_0", 32'(instr_cnt), 0);
        run = 1'b0;
        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
